// File: rtl/pam4_rx_pkg.sv
// Shared definitions for the PAM4 lane checker: FSM states, slicer thermometer codes,
// the PRBS7 polynomial and seed, and the level-to-bits Gray map.
package pam4_rx_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] THERMO_L0 = 3'b000;
  localparam logic [2:0] THERMO_L1 = 3'b001;
  localparam logic [2:0] THERMO_L2 = 3'b011;
  localparam logic [2:0] THERMO_L3 = 3'b111;

  // x^7 + x^6 + 1: feedback is state[6] ^ state[5]
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  function automatic logic [1:0] gray_map(input logic [1:0] level);
    return {level[1], level[1] ^ level[0]};
  endfunction

endpackage

// File: rtl/pam4_prbs7_gen.sv
// PRBS7 generator stepping two bits per symbol; prbs2_o shows the next pair, first bit in the MSB.
// load_i reseeds to 7'h7F and takes priority over adv_i.
module pam4_prbs7_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       adv_i,
  output logic [1:0] prbs2_o
);
  import pam4_rx_pkg::*;

  logic [6:0] lfsr_q, lfsr_d, step1;
  logic       bit0, bit1;

  always_comb begin
    bit0    = ^(lfsr_q & PRBS7_TAPS);
    step1   = {lfsr_q[5:0], bit0};
    bit1    = ^(step1 & PRBS7_TAPS);
    prbs2_o = {bit0, bit1};
    lfsr_d  = lfsr_q;
    if (load_i) begin
      lfsr_d = PRBS7_SEED;
    end else if (adv_i) begin
      lfsr_d = {step1[5:0], bit1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/pam4_rx_checker.sv
// PAM4 lane checker: thermometer decode, sync hunt/verify/lock, PRBS7 payload and statistics.
// Define PAM4_GRAY_EN to map levels to bits through the Gray code (transmitter must match).
module pam4_rx_checker #(
  parameter int                       SYNC_SYMS    = 8,
  parameter logic [2*SYNC_SYMS-1:0]   SYNC_WORD    = 16'hF0C3,
  parameter int                       PAYLOAD_SYMS = 248,
  parameter int                       LOCK_FRAMES  = 2,
  parameter int                       MISS_MAX     = 3,
  parameter int                       CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_valid,
  input  logic [2:0]       slicer_thermo,
  input  logic             clear_cnt,
  output logic [1:0]       sym_out,
  output logic             sym_out_valid,
  output logic             locked,
  output logic             frame_start,
  output logic             lock_lost,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] thermo_err_cnt
);
  import pam4_rx_pkg::*;

  localparam int FRAME  = SYNC_SYMS + PAYLOAD_SYMS;
  localparam int POS_W  = $clog2(FRAME);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(MISS_MAX + 1);
  localparam int SR_W   = 2 * SYNC_SYMS - 2;

  localparam logic [POS_W-1:0] POS_SYNC_END = POS_W'(SYNC_SYMS - 1);
  localparam logic [POS_W-1:0] POS_PAY0     = POS_W'(SYNC_SYMS);
  localparam logic [POS_W-1:0] POS_LAST     = POS_W'(FRAME - 1);

  state_e             state_q;
  logic [POS_W-1:0]   pos_q, pos_nxt;
  logic [GOOD_W-1:0]  good_q;
  logic [MISS_W-1:0]  miss_q;
  // Only the previous symbols are stored; the live symbol completes the sync word.
  logic [SR_W-1:0]    sr_q;
  logic [1:0]         sym_out_q;
  logic               sym_out_valid_q, locked_q, frame_start_q, lock_lost_q;
  logic [CNT_W-1:0]   bit_err_q, bit_err_d, frame_q, frame_d, therr_q, therr_d;

  logic [1:0]         level, sym_bits, prbs2, err_bits, nerr;
  logic               thermo_bad, sync_hit, in_payload, prbs_load, prbs_adv;
  logic [2*SYNC_SYMS-1:0] sr_word;

  always_comb begin
    thermo_bad = 1'b0;
    case (slicer_thermo)
      THERMO_L0: level = 2'd0;
      THERMO_L1: level = 2'd1;
      THERMO_L2: level = 2'd2;
      THERMO_L3: level = 2'd3;
      default: begin
        level      = 2'd0;
        thermo_bad = 1'b1;
      end
    endcase
`ifdef PAM4_GRAY_EN
    sym_bits = gray_map(level);
`else
    sym_bits = level;
`endif
    sr_word    = {sr_q, sym_bits};
    sync_hit   = (sr_word == SYNC_WORD);
    in_payload = (pos_q >= POS_PAY0);
    pos_nxt    = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    err_bits   = sym_bits ^ prbs2;
    nerr       = {err_bits[1] & err_bits[0], err_bits[1] ^ err_bits[0]};
    prbs_load  = sym_valid && ((state_q == HUNT && sync_hit) ||
                               (state_q != HUNT && pos_q == POS_SYNC_END));
    prbs_adv   = sym_valid && state_q != HUNT && in_payload;
  end

  pam4_prbs7_gen u_prbs (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (prbs_load),
    .adv_i  (prbs_adv),
    .prbs2_o(prbs2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= HUNT;
      pos_q           <= '0;
      good_q          <= '0;
      miss_q          <= '0;
      sr_q            <= '0;
      sym_out_q       <= '0;
      sym_out_valid_q <= 1'b0;
      locked_q        <= 1'b0;
      frame_start_q   <= 1'b0;
      lock_lost_q     <= 1'b0;
    end else begin
      sym_out_valid_q <= sym_valid;
      frame_start_q   <= 1'b0;
      lock_lost_q     <= 1'b0;
      if (sym_valid) begin
        sym_out_q <= sym_bits;
        sr_q      <= sr_word[SR_W-1:0];
        case (state_q)
          HUNT: begin
            if (sync_hit) begin
              state_q <= VERIFY;
              good_q  <= GOOD_W'(1);
              pos_q   <= POS_PAY0;
            end
          end
          VERIFY: begin
            frame_start_q <= (pos_q == POS_PAY0);
            pos_q         <= pos_nxt;
            if (pos_q == POS_SYNC_END) begin
              if (!sync_hit) begin
                state_q <= HUNT;
              end else begin
                good_q <= good_q + 1'b1;
                if (good_q == GOOD_W'(LOCK_FRAMES - 1)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                  miss_q   <= '0;
                end
              end
            end
          end
          LOCKED: begin
            frame_start_q <= (pos_q == POS_PAY0);
            pos_q         <= pos_nxt;
            if (pos_q == POS_SYNC_END) begin
              if (sync_hit) begin
                miss_q <= '0;
              end else if (miss_q == MISS_W'(MISS_MAX - 1)) begin
                state_q     <= HUNT;
                locked_q    <= 1'b0;
                lock_lost_q <= 1'b1;
                miss_q      <= '0;
              end else begin
                miss_q <= miss_q + 1'b1;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    bit_err_d = bit_err_q;
    frame_d   = frame_q;
    therr_d   = therr_q;
    if (sym_valid) begin
      if (thermo_bad) therr_d = sat_add(therr_q, 2'd1);
      if (state_q == LOCKED && in_payload) bit_err_d = sat_add(bit_err_q, nerr);
      if (state_q == LOCKED && pos_q == POS_SYNC_END && sync_hit) frame_d = sat_add(frame_q, 2'd1);
    end
    if (clear_cnt) begin
      bit_err_d = '0;
      frame_d   = '0;
      therr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_err_q <= '0;
      frame_q   <= '0;
      therr_q   <= '0;
    end else begin
      bit_err_q <= bit_err_d;
      frame_q   <= frame_d;
      therr_q   <= therr_d;
    end
  end

  assign sym_out        = sym_out_q;
  assign sym_out_valid  = sym_out_valid_q;
  assign locked         = locked_q;
  assign frame_start    = frame_start_q;
  assign lock_lost      = lock_lost_q;
  assign bit_err_cnt    = bit_err_q;
  assign frame_cnt      = frame_q;
  assign thermo_err_cnt = therr_q;

endmodule

// File: tb/tb_pam4_rx_checker.sv
// Bench for pam4_rx_checker: transmitter model, decode vector table and a frame-level reference model.
`timescale 1ns/1ps
module tb_pam4_rx_checker;
  localparam int SYNC_SYMS    = 8;
  localparam int PAYLOAD_SYMS = 248;
  localparam int FRAME        = SYNC_SYMS + PAYLOAD_SYMS;
  localparam logic [15:0] SYNC_WORD = 16'hF0C3;

  logic        clk = 1'b0, rst_n = 1'b0, sym_valid = 1'b0, clear_cnt = 1'b0;
  logic [2:0]  slicer_thermo = 3'b000;
  logic [1:0]  sym_out;
  logic        sym_out_valid, locked, frame_start, lock_lost;
  logic [15:0] bit_err_cnt, frame_cnt, thermo_err_cnt;

  pam4_rx_checker dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .slicer_thermo(slicer_thermo),
    .clear_cnt(clear_cnt), .sym_out(sym_out), .sym_out_valid(sym_out_valid),
    .locked(locked), .frame_start(frame_start), .lock_lost(lock_lost),
    .bit_err_cnt(bit_err_cnt), .frame_cnt(frame_cnt), .thermo_err_cnt(thermo_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, ll_seen = 0;
  bit idle_en = 1'b0;

  // Transmit frame image and per-position impairments.
  bit         pbits[2*PAYLOAD_SYMS+7];
  logic [1:0] sync_sym[SYNC_SYMS];
  logic [1:0] flip[FRAME];
  int         raw_th[FRAME];
  bit         clr_at[FRAME];

  // Reference model state.
  int         m_st, m_pos, m_good, m_miss, m_be, m_fc, m_te;
  logic [1:0] m_sym;
  bit         m_vld, m_fs, m_ll;
  logic [1:0] hist[$];

  typedef struct {
    logic [2:0] th;
    int         lvl;
    int         ill;
  } dec_vec_t;
  dec_vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] lvl2bits(input int l);
`ifdef PAM4_GRAY_EN
    case (l)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
`else
    return 2'(l);
`endif
  endfunction

  function automatic int bits2lvl(input logic [1:0] b);
    for (int l = 0; l < 4; l++) if (lvl2bits(l) == b) return l;
    return 0;
  endfunction

  function automatic logic [2:0] lvl2th(input int l);
    case (l)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int th2lvl(input logic [2:0] th);
    case (th)
      3'b000: return 0;
      3'b001: return 1;
      3'b011: return 2;
      3'b111: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] frame_bits(input int pos);
    if (pos < SYNC_SYMS) return sync_sym[pos];
    return {pbits[2*(pos-SYNC_SYMS)], pbits[2*(pos-SYNC_SYMS)+1]};
  endfunction

  function automatic int sat(input int c, input int inc);
    return (c + inc > 65535) ? 65535 : c + inc;
  endfunction

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_good = 0; m_miss = 0;
    m_be = 0; m_fc = 0; m_te = 0;
    m_sym = 2'b00; m_vld = 0; m_fs = 0; m_ll = 0;
    hist.delete();
    for (int i = 0; i < SYNC_SYMS; i++) hist.push_back(2'b00);
  endtask

  // Per-symbol reference: 0=hunting, 1=verifying, 2=locked.
  task automatic model_cycle(input logic v, input logic [2:0] th, input logic clr);
    int lvl;
    logic [1:0] b;
    bit match;
    m_vld = v; m_fs = 0; m_ll = 0;
    if (v) begin
      lvl = th2lvl(th);
      if (lvl < 0) begin
        lvl = 0;
        m_te = sat(m_te, 1);
      end
      b = lvl2bits(lvl);
      m_sym = b;
      hist.push_back(b);
      void'(hist.pop_front());
      match = 1;
      for (int i = 0; i < SYNC_SYMS; i++) if (hist[i] != sync_sym[i]) match = 0;
      if (m_st == 0) begin
        if (match) begin m_st = 1; m_good = 1; m_pos = SYNC_SYMS; end
      end else begin
        m_fs = (m_pos == SYNC_SYMS);
        if (m_pos == SYNC_SYMS - 1) begin
          if (m_st == 1) begin
            if (!match) m_st = 0;
            else begin
              m_good++;
              if (m_good == 2) begin m_st = 2; m_miss = 0; end
            end
          end else begin
            if (match) begin m_miss = 0; m_fc = sat(m_fc, 1); end
            else begin
              m_miss++;
              if (m_miss == 3) begin m_st = 0; m_ll = 1; end
            end
          end
        end else if (m_pos >= SYNC_SYMS && m_st == 2) begin
          m_be = sat(m_be, $countones(b ^ frame_bits(m_pos)));
        end
        m_pos = (m_pos + 1) % FRAME;
      end
    end
    if (clr) begin m_be = 0; m_fc = 0; m_te = 0; end
  endtask

  task automatic compare_all();
    chk("sym_out_valid", 32'(sym_out_valid), 32'(m_vld));
    chk("sym_out", 32'(sym_out), 32'(m_sym));
    chk("locked", 32'(locked), 32'(m_st == 2));
    chk("frame_start", 32'(frame_start), 32'(m_fs));
    chk("lock_lost", 32'(lock_lost), 32'(m_ll));
    chk("bit_err_cnt", 32'(bit_err_cnt), 32'(m_be));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    chk("thermo_err_cnt", 32'(thermo_err_cnt), 32'(m_te));
  endtask

  task automatic cycle(input logic v, input logic [2:0] th, input logic clr);
    @(negedge clk);
    sym_valid = v; slicer_thermo = th; clear_cnt = clr;
    @(posedge clk);
    #1;
    model_cycle(v, th, clr);
    compare_all();
    if (lock_lost === 1'b1) ll_seen++;
  endtask

  task automatic clear_mods();
    for (int i = 0; i < FRAME; i++) begin flip[i] = 2'b00; raw_th[i] = -1; clr_at[i] = 0; end
  endtask

  task automatic send_sym(input int pos);
    logic [2:0] th;
    if (idle_en && $urandom_range(0, 5) == 0) cycle(1'b0, 3'($urandom_range(0, 7)), 1'b0);
    th = lvl2th(bits2lvl(frame_bits(pos) ^ flip[pos]));
    if (raw_th[pos] >= 0) th = 3'(raw_th[pos]);
    cycle(1'b1, th, clr_at[pos]);
    if (th2lvl(th) < 0) chk("thermo_level0", 32'(sym_out), 32'(lvl2bits(0)));
  endtask

  task automatic send_frame(input int from, input int to);
    for (int p = from; p <= to; p++) send_sym(p);
  endtask

  task automatic clean_frames(input int n);
    clear_mods();
    for (int i = 0; i < n; i++) send_frame(0, FRAME - 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sw;
    int illegal_seen;
    bit p[2*PAYLOAD_SYMS+14];

    tbl[0] = '{3'b000, 0, 0}; tbl[1] = '{3'b001, 1, 0};
    tbl[2] = '{3'b011, 2, 0}; tbl[3] = '{3'b111, 3, 0};
    tbl[4] = '{3'b010, 0, 1}; tbl[5] = '{3'b100, 0, 1};
    tbl[6] = '{3'b101, 0, 1}; tbl[7] = '{3'b110, 0, 1};

    // PRBS7 bit stream from seed 7'h7F: b[n] = b[n-7] ^ b[n-6].
    for (int i = 0; i < 7; i++) p[i] = 1'b1;
    for (int n = 7; n < 2*PAYLOAD_SYMS + 7; n++) p[n] = p[n-7] ^ p[n-6];
    for (int k = 0; k < 2*PAYLOAD_SYMS; k++) pbits[k] = p[k+7];
    sw = SYNC_WORD;
    for (int i = 0; i < SYNC_SYMS; i++) sync_sym[i] = sw[15-2*i -: 2];
    clear_mods();
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Decode table, applied while hunting.
    illegal_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].th, 1'b0);
      illegal_seen += tbl[i].ill;
      chk("decode_sym", 32'(sym_out), 32'(lvl2bits(tbl[i].lvl)));
      chk("decode_therr", 32'(thermo_err_cnt), 32'(illegal_seen));
    end
    cycle(1'b0, 3'b000, 1'b1);
    chk("clear_therr", 32'(thermo_err_cnt), 32'd0);

    // Acquisition on clean frames.
    clean_frames(1);
    chk("verify_not_locked", 32'(locked), 32'd0);
    clean_frames(1);
    chk("locked_after_2nd", 32'(locked), 32'd1);
    chk("frame_cnt_at_lock", 32'(frame_cnt), 32'd0);
    clean_frames(3);
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
    chk("bit_err_clean", 32'(bit_err_cnt), 32'd0);

    // Payload bit errors at payload symbols 10 and 20.
    idle_en = 1'b1;
    clear_mods(); flip[SYNC_SYMS+10] = 2'b01; send_frame(0, FRAME - 1);
    chk("bit_err_1", 32'(bit_err_cnt), 32'd1);
    clear_mods(); flip[SYNC_SYMS+20] = 2'b11; send_frame(0, FRAME - 1);
    chk("bit_err_3", 32'(bit_err_cnt), 32'd3);

    // Sync misses: two tolerated, three drop lock.
    ll_seen = 0;
    clear_mods(); flip[0] = 2'b11;
    send_frame(0, FRAME - 1); send_frame(0, FRAME - 1);
    chk("two_misses_locked", 32'(locked), 32'd1);
    clean_frames(1);
    for (int i = 0; i < 2; i++) begin
      clear_mods(); flip[0] = 2'b11; send_frame(0, FRAME - 1);
    end
    chk("two_more_misses_locked", 32'(locked), 32'd1);
    chk("no_lock_lost_yet", 32'(ll_seen), 32'd0);
    clear_mods(); flip[0] = 2'b11; send_frame(0, FRAME - 1);
    chk("lock_lost_pulse", 32'(ll_seen), 32'd1);
    chk("unlocked_after_3", 32'(locked), 32'd0);
    clean_frames(2);
    chk("relocked", 32'(locked), 32'd1);

    // Illegal thermometer codes mid-payload.
    cycle(1'b0, 3'b000, 1'b1);
    clear_mods(); raw_th[50] = 3'b101; raw_th[60] = 3'b010; send_frame(0, FRAME - 1);
    chk("therr_2", 32'(thermo_err_cnt), 32'd2);

    // Saturation of bit_err_cnt: 132 fully inverted payloads plus 31 symbols gives 16'hFFFE.
    idle_en = 1'b0;
    cycle(1'b0, 3'b000, 1'b1);
    clear_mods();
    for (int q = SYNC_SYMS; q < FRAME; q++) flip[q] = 2'b11;
    for (int f = 0; f < 132; f++) send_frame(0, FRAME - 1);
    clear_mods();
    for (int q = SYNC_SYMS; q < SYNC_SYMS + 31; q++) flip[q] = 2'b11;
    send_frame(0, FRAME - 1);
    chk("bit_err_fffe", 32'(bit_err_cnt), 32'hFFFE);
    clear_mods(); flip[SYNC_SYMS] = 2'b11; flip[SYNC_SYMS+1] = 2'b01; send_frame(0, FRAME - 1);
    chk("bit_err_sat", 32'(bit_err_cnt), 32'hFFFF);
    clear_mods(); flip[20] = 2'b11; clr_at[20] = 1; send_frame(0, FRAME - 1);
    chk("clear_beats_err", 32'(bit_err_cnt), 32'd0);
    chk("clear_frame_cnt", 32'(frame_cnt), 32'd0);

    // Randomised impairments against the reference model.
    idle_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      clear_mods();
      if ($urandom_range(0, 3) == 0) flip[$urandom_range(0, SYNC_SYMS-1)] = 2'($urandom_range(1, 3));
      for (int k = 0; k < 3; k++) flip[$urandom_range(SYNC_SYMS, FRAME-1)] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) raw_th[$urandom_range(SYNC_SYMS, FRAME-1)] = int'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) clr_at[$urandom_range(0, FRAME-1)] = 1;
      send_frame(0, FRAME - 1);
    end

    // Reset in the middle of a payload.
    clean_frames(3);
    chk("locked_before_rst", 32'(locked), 32'd1);
    clear_mods(); send_frame(0, 99);
    @(negedge clk);
    sym_valid = 1'b0; clear_cnt = 1'b0; rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(100, FRAME - 1);
    chk("rst_unlocked", 32'(locked), 32'd0);
    clean_frames(1);
    chk("rst_verify", 32'(locked), 32'd0);
    clean_frames(1);
    chk("rst_relocked", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
